// File: rtl/eg_event_scheduler_if.sv
// PPI producer publish channel: the scheduler drives req/idx/addr, the producer returns ack.
interface eg_event_scheduler_if #(
    parameter int NUM_EVENTS = 8,
    parameter int PAR_AW     = 12
);
    localparam int IW = $clog2(NUM_EVENTS);

    logic              pub_req_o;
    logic [IW-1:0]     pub_idx_o;
    logic [PAR_AW-1:0] pub_addr_o;
    logic              pub_ack_i;

    modport master (output pub_req_o, pub_idx_o, pub_addr_o, input pub_ack_i);
    modport slave  (input pub_req_o, pub_idx_o, pub_addr_o, output pub_ack_i);
endinterface

// File: rtl/eg_event_scheduler.sv
// Event scheduler: latches event pulses, publishes queued events round-robin over req/ack,
// drives the combined IRQ. Optional ack timeout: define EG_SCHED_TIMEOUT_EN.
module eg_event_scheduler #(
    parameter int NUM_EVENTS     = 8,
    parameter int PAR_AW         = 12,
    parameter int EVENT_BASE     = 'h100,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_EVENTS-1:0] event_trig_i,
    input  logic [NUM_EVENTS-1:0] clr_pending_i,
    input  logic [NUM_EVENTS-1:0] irq_enable_i,
    eg_event_scheduler_if.master  pub,
    output logic [NUM_EVENTS-1:0] pending_o,
    output logic [NUM_EVENTS-1:0] overrun_o,
    output logic                  irq_o,
    output logic                  timeout_o
);
    localparam int IW = $clog2(NUM_EVENTS);

    if (NUM_EVENTS < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
        $error("eg_event_scheduler: NUM_EVENTS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state;
    logic [NUM_EVENTS-1:0] queued;
    logic [NUM_EVENTS-1:0] done_mask;
    logic [IW-1:0]         last;
    logic [IW-1:0]         sel;
    logic                  ack_fire;

    function automatic logic [PAR_AW-1:0] addr_of(input logic [IW-1:0] i);
        return PAR_AW'(EVENT_BASE) + (PAR_AW'(i) << 2);
    endfunction

    assign ack_fire = (state == REQ) && pub.pub_ack_i;

    always_comb begin
        done_mask = '0;
        if (ack_fire) done_mask[pub.pub_idx_o] = 1'b1;
    end

    // Walk from farthest to nearest so the first queued event after 'last' wins.
    always_comb begin
        int cand;
        cand = 0;
        sel  = last;
        for (int k = NUM_EVENTS; k >= 1; k--) begin
            cand = (int'(last) + k) % NUM_EVENTS;
            if (queued[IW'(cand)]) sel = IW'(cand);
        end
    end

`ifdef EG_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            queued         <= '0;
            pending_o      <= '0;
            overrun_o      <= '0;
            irq_o          <= 1'b0;
            last           <= IW'(NUM_EVENTS - 1);
            pub.pub_req_o  <= 1'b0;
            pub.pub_idx_o  <= '0;
            pub.pub_addr_o <= PAR_AW'(EVENT_BASE);
`ifdef EG_SCHED_TIMEOUT_EN
            tmo_cnt        <= '0;
            timeout_o      <= 1'b0;
`endif
        end else begin
            // A trigger beats a same-cycle clear or ack; a retrigger during its own ack is not an overrun.
            pending_o <= event_trig_i | (pending_o & ~clr_pending_i);
            overrun_o <= (overrun_o | (event_trig_i & queued & ~done_mask)) & ~clr_pending_i;
            queued    <= event_trig_i | (queued & ~done_mask);
            irq_o     <= |(pending_o & irq_enable_i);

            case (state)
                IDLE: begin
                    if (|queued) begin
                        pub.pub_idx_o  <= sel;
                        pub.pub_addr_o <= addr_of(sel);
                        pub.pub_req_o  <= 1'b1;
                        state          <= REQ;
`ifdef EG_SCHED_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end
                end
                REQ: begin
                    if (pub.pub_ack_i) begin
                        pub.pub_req_o <= 1'b0;
                        last          <= pub.pub_idx_o;
                        state         <= IDLE;
                    end
`ifdef EG_SCHED_TIMEOUT_EN
                    // Give up on this event for now; it stays queued and others get a turn.
                    else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        pub.pub_req_o <= 1'b0;
                        last          <= pub.pub_idx_o;
                        timeout_o     <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eg_event_scheduler.sv
// Directed bench for eg_event_scheduler with a per-cycle behavioural model and a publish log.
module tb_eg_event_scheduler;
    localparam int N    = 8;
    localparam int AW   = 12;
    localparam int BASE = 'h100;
    localparam int TMO  = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] trig = '0, clr = '0, en = '0;
    logic         ack = 1'b0;
    logic [N-1:0] pending, overrun;
    logic         irq, timeout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    eg_event_scheduler_if #(.NUM_EVENTS(N), .PAR_AW(AW)) pub_if ();
    assign pub_if.pub_ack_i = ack;

    eg_event_scheduler #(.NUM_EVENTS(N), .PAR_AW(AW), .EVENT_BASE(BASE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .event_trig_i(trig), .clr_pending_i(clr),
        .irq_enable_i(en), .pub(pub_if), .pending_o(pending), .overrun_o(overrun),
        .irq_o(irq), .timeout_o(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [N-1:0] m_pend = '0, m_que = '0, m_ovr = '0;
    int         m_last = N - 1;
    bit         m_req = 0, m_irq = 0, m_tmo = 0;
    int         m_idx = 0, m_cnt = 0;

    function automatic int pick(input int l, input bit [N-1:0] q);
        for (int k = 1; k <= N; k++) if (q[(l + k) % N]) return (l + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pend = '0; m_que = '0; m_ovr = '0; m_last = N - 1;
            m_req = 0; m_idx = 0; m_irq = 0; m_tmo = 0; m_cnt = 0;
        end else begin
            bit [N-1:0] q0;
            bit         fire;
            q0     = m_que;
            fire   = m_req && ack;
            m_irq  = |(m_pend & en);
            for (int i = 0; i < N; i++) begin
                bit acked;
                acked = fire && (m_idx == i);
                if (clr[i]) m_ovr[i] = 0;
                else if (trig[i] && q0[i] && !acked) m_ovr[i] = 1;
                m_pend[i] = trig[i] || (m_pend[i] && !clr[i]);
                m_que[i]  = trig[i] || (q0[i] && !acked);
            end
            if (!m_req) begin
                if (q0 != 0) begin m_idx = pick(m_last, q0); m_req = 1; m_cnt = 0; end
            end else if (fire) begin
                m_req = 0; m_last = m_idx;
            end
`ifdef EG_SCHED_TIMEOUT_EN
            else begin
                m_cnt++;
                if (m_cnt == TMO) begin m_req = 0; m_last = m_idx; m_tmo = 1; end
            end
`endif
        end
    end

    // ---------------- per-cycle compare + publish log ----------------
    int   pubs[$];
    int   pub_cyc[$];
    logic prev_req = 0;
    int   prev_idx = 0;

    always @(negedge clk) begin
        logic [AW-1:0] ea;
        ea = AW'(BASE + 4 * m_idx);
        chk("req", 32'(pub_if.pub_req_o), 32'(m_req));
        if (m_req) begin
            chk("idx", 32'(pub_if.pub_idx_o), 32'(m_idx));
            chk("addr", 32'(pub_if.pub_addr_o), 32'(ea));
        end
        if (prev_req && pub_if.pub_req_o) chk("idx_stable", 32'(pub_if.pub_idx_o), 32'(prev_idx));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        if (pub_if.pub_req_o && ack) begin
            pubs.push_back(int'(pub_if.pub_idx_o));
            pub_cyc.push_back(cyc);
        end
        prev_req = pub_if.pub_req_o;
        prev_idx = int'(pub_if.pub_idx_o);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn = 0; trig = '0; clr = '0; ack = 0; en = '0;
        step(); step();
        resetn = 1;
        pubs.delete();
        pub_cyc.delete();
    endtask

    task automatic chk_pubs(input string name, input int exp[$]);
        chk({name, "_count"}, 32'(pubs.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < pubs.size(); i++)
            chk(name, 32'(pubs[i]), 32'(exp[i]));
    endtask

    typedef struct {logic [N-1:0] t; logic [N-1:0] c; logic a;} vec_t;
    vec_t tbl[$] = '{
        '{8'h11, 8'h00, 1'b0}, '{8'h00, 8'h00, 1'b0}, '{8'h10, 8'h00, 1'b1}, '{8'hC0, 8'h01, 1'b1},
        '{8'h00, 8'h10, 1'b0}, '{8'h40, 8'h40, 1'b0}, '{8'h00, 8'h00, 1'b1}, '{8'h03, 8'hFF, 1'b1},
        '{8'h00, 8'h00, 1'b1}, '{8'h80, 8'h00, 1'b0}, '{8'h80, 8'h00, 1'b0}, '{8'h00, 8'h80, 1'b1},
        '{8'h3C, 8'h00, 1'b1}, '{8'h00, 8'h00, 1'b1}, '{8'h08, 8'h00, 1'b1}, '{8'h00, 8'h0F, 1'b1}
    };

    initial begin
        repeat (3) step();
        chk("rst_req", 32'(pub_if.pub_req_o), 0);
        chk("rst_idx", 32'(pub_if.pub_idx_o), 0);
        chk("rst_addr", 32'(pub_if.pub_addr_o), 'h100);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_timeout", 32'(timeout), 0);
        resetn = 1;
        step();

        // single event 3 with IRQ enabled
        en = 8'h08; trig = 8'h08;
        step(); trig = '0;
        chk("t1_pend_n1", 32'(pending), 'h08);
        chk("t1_req_n1", 32'(pub_if.pub_req_o), 0);
        step();
        chk("t1_req_n2", 32'(pub_if.pub_req_o), 1);
        chk("t1_idx", 32'(pub_if.pub_idx_o), 3);
        chk("t1_addr", 32'(pub_if.pub_addr_o), 'h10C);
        chk("t1_irq_n2", 32'(irq), 1);
        ack = 1;
        step(); ack = 0;
        chk("t1_req_drop", 32'(pub_if.pub_req_o), 0);
        chk("t1_pend_hold", 32'(pending), 'h08);
        chk_pubs("t1_pubs", '{3});

        // three simultaneous events, ack always high
        do_reset();
        ack = 1; trig = 8'h85;
        step(); trig = '0;
        repeat (8) step();
        chk_pubs("t2_order", '{0, 2, 7});
        if (pub_cyc.size() == 3) begin
            chk("t2_gap01", 32'(pub_cyc[1] - pub_cyc[0]), 2);
            chk("t2_gap12", 32'(pub_cyc[2] - pub_cyc[1]), 2);
        end
        ack = 0;

        // coalesced retrigger -> overrun, then software clear
        do_reset();
        en = 8'h04; trig = 8'h04;
        step(); trig = '0;
        step(); trig = 8'h04;
        step(); trig = '0;
        step();
        chk("t3_overrun", 32'(overrun), 'h04);
        ack = 1;
        step(); ack = 0;
        repeat (4) step();
        chk_pubs("t3_once", '{2});
        chk("t3_irq_before", 32'(irq), 1);
        clr = 8'h04;
        step(); clr = '0;
        chk("t3_pend_clr", 32'(pending), 0);
        chk("t3_ovr_clr", 32'(overrun), 0);
        chk("t3_irq_n1", 32'(irq), 1);
        step();
        chk("t3_irq_n2", 32'(irq), 0);

        // trigger and clear on the same event in one cycle
        do_reset();
        ack = 1; trig = 8'h20; clr = 8'h20;
        step(); trig = '0; clr = '0;
        chk("t4_pend", 32'(pending), 'h20);
        chk("t4_ovr", 32'(overrun), 0);
        repeat (4) step();
        chk_pubs("t4_pub", '{5});
        ack = 0;

        // reset in the middle of a handshake
        do_reset();
        trig = 8'h02;
        step(); trig = '0;
        step();
        chk("t5_req_pre", 32'(pub_if.pub_req_o), 1);
        ack = 1; resetn = 0;
        #1;
        chk("t5_req_rst", 32'(pub_if.pub_req_o), 0);
        chk("t5_idx_rst", 32'(pub_if.pub_idx_o), 0);
        chk("t5_addr_rst", 32'(pub_if.pub_addr_o), 'h100);
        chk("t5_pend_rst", 32'(pending), 0);
        step(); ack = 0;
        step(); resetn = 1;
        repeat (5) step();
        chk("t5_no_pub", 32'(pubs.size()), 0);
        chk("t5_req_idle", 32'(pub_if.pub_req_o), 0);

        // mixed directed table, checked by the model every cycle
        do_reset();
        en = 8'hA5;
        foreach (tbl[i]) begin
            trig = tbl[i].t; clr = tbl[i].c; ack = tbl[i].a;
            step();
        end
        trig = '0; clr = '0; ack = 1;
        repeat (20) step();
        chk("t6_drained_req", 32'(pub_if.pub_req_o), 0);
        ack = 0;

`ifdef EG_SCHED_TIMEOUT_EN
        // ack timeout: event 1 times out, event 4 served, then 1 retried
        do_reset();
        trig = 8'h12;
        step(); trig = '0;
        repeat (20) step();
        chk("t7_timeout", 32'(timeout), 1);
        ack = 1;
        repeat (6) step();
        ack = 0;
        chk_pubs("t7_order", '{4, 1});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
